// File: rtl/mac_pkg.sv
// Shared definitions for the mac_pipe multiply-accumulate block.
// Contents:
//   mac_state_e : controller state encoding (IDLE, ACCUM, DRAIN, HOLD)
//   sat_max/min : signed clamp bounds for a given accumulator width.
//                 They return SAT_W bits; callers slice the low OUTW bits.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mac_state_e;

  localparam int unsigned SAT_W = 128;

  // Largest positive value of a w-bit two's-complement number: 2^(w-1)-1.
  function automatic logic [SAT_W-1:0] sat_max(input int unsigned w);
    return (128'd1 << (w - 32'd1)) - 128'd1;
  endfunction

  // Most negative w-bit value. Its low w bits are 1000...0.
  function automatic logic [SAT_W-1:0] sat_min(input int unsigned w);
    return 128'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Registered signed multiplier with MULT_STAGES pipeline registers.
// A valid bit travels alongside each product. A stage's data register
// loads only when valid data arrives, so bubbles leave stored products
// unchanged.
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   valid_i        : operand pair present this cycle
//   a_i, b_i       : signed INW-bit operands
//   valid_o        : prod_o holds a product leaving the pipeline
//   prod_o         : full-width 2*INW-bit signed product
module mult_pipe
  import mac_pkg::*;
#(
  parameter int INW         = 16,
  parameter int MULT_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic signed [INW-1:0] a_i,
  input  logic signed [INW-1:0] b_i,
  output logic                  valid_o,
  output logic signed [2*INW-1:0] prod_o
);

  logic signed [2*INW-1:0] prod_q [MULT_STAGES];
  logic [MULT_STAGES-1:0]  valid_q;

  // Pipeline registers: multiply in stage 0, then shift products and valid bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int k = 0; k < MULT_STAGES; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        prod_q[0] <= (2*INW)'(a_i) * (2*INW)'(b_i);
      end
      for (int k = 1; k < MULT_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          prod_q[k] <= prod_q[k-1];
        end
      end
    end
  end

  assign valid_o = valid_q[MULT_STAGES-1];
  assign prod_o  = prod_q[MULT_STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate over vectors of vec_len operand pairs.
// The first accepted pair seeds the accumulator with init_value. Each later
// product is added as it leaves the multiplier. out_valid is set one cycle
// after the final add, and out is held until the consumer accepts it.
// Optional feature: define MAC_PIPE_SATURATE_EN to use saturating addition.
// A saturating add that clamps sets ovf. When the macro is not defined,
// additions wrap and ovf is tied to 0.
// Ports:
//   clk, reset                    : clock and synchronous active-high reset
//   in_valid/in_ready             : operand-pair handshake
//   input0, input1                : signed INW-bit operands
//   init_value, vec_len           : seed value and vector length, sampled with the first pair
//   out/out_valid/out_ready       : result handshake (OUTW-bit signed result)
//   ovf                           : sticky saturation flag for the current result
module mac_pipe
  import mac_pkg::*;
#(
  parameter int INW         = 16,
  parameter int OUTW        = 64,
  parameter int MULT_STAGES = 2,
  parameter int LENW        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [INW-1:0]  input0,
  input  logic signed [INW-1:0]  input1,
  input  logic signed [INW-1:0]  init_value,
  input  logic [LENW-1:0]        vec_len,
  output logic signed [OUTW-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf
);

  mac_state_e state_q, state_d;
  logic [LENW-1:0]        len_q, len_d;
  logic [LENW-1:0]        cnt_q, cnt_d;
  logic [LENW-1:0]        acc_cnt_q, acc_cnt_d;
  logic signed [OUTW-1:0] acc_q, acc_d;
  logic signed [OUTW-1:0] out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ovf_q, ovf_d;

  logic                    in_xfer_s;
  logic                    p_valid_s;
  logic signed [2*INW-1:0] prod_s;
  logic signed [OUTW-1:0]  p_ext_s;
  logic signed [OUTW-1:0]  acc_sum_s;
  logic                    sat_hit_s;
  logic [LENW-1:0]         len_in_s;

  mult_pipe #(
    .INW         (INW),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (in_xfer_s),
    .a_i     (input0),
    .b_i     (input1),
    .valid_o (p_valid_s),
    .prod_o  (prod_s)
  );

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign in_xfer_s = in_valid && in_ready;
  assign p_ext_s   = OUTW'(prod_s);
  // A vector length of zero is treated as a single-product vector.
  assign len_in_s  = (vec_len == '0) ? LENW'(1) : vec_len;

`ifdef MAC_PIPE_SATURATE_EN
  localparam logic [SAT_W-1:0] SMAX_W = sat_max(OUTW);
  localparam logic [SAT_W-1:0] SMIN_W = sat_min(OUTW);
  localparam logic [OUTW-1:0]  SMAX   = SMAX_W[OUTW-1:0];
  localparam logic [OUTW-1:0]  SMIN   = SMIN_W[OUTW-1:0];
  logic [OUTW:0] sum_wide_s;

  // One guard bit exposes overflow. When the top two bits differ, the add
  // overflowed, and the guard bit gives the direction.
  always_comb begin
    sum_wide_s = {acc_q[OUTW-1], acc_q} + {p_ext_s[OUTW-1], p_ext_s};
    sat_hit_s  = sum_wide_s[OUTW] ^ sum_wide_s[OUTW-1];
    if (!sat_hit_s) begin
      acc_sum_s = sum_wide_s[OUTW-1:0];
    end else if (sum_wide_s[OUTW]) begin
      acc_sum_s = SMIN;
    end else begin
      acc_sum_s = SMAX;
    end
  end
`else
  assign acc_sum_s = acc_q + p_ext_s;
  assign sat_hit_s = 1'b0;
`endif

  // Next-state logic for the controller, counters, accumulator and result.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_cnt_d   = acc_cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    if (p_valid_s) begin
      acc_d     = acc_sum_s;
      acc_cnt_d = LENW'(acc_cnt_q + LENW'(1));
      ovf_d     = ovf_q | sat_hit_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (in_xfer_s) begin
          len_d     = len_in_s;
          cnt_d     = LENW'(1);
          acc_cnt_d = '0;
          acc_d     = OUTW'(init_value);
          ovf_d     = 1'b0;
          state_d   = (len_in_s == LENW'(1)) ? DRAIN : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_xfer_s) begin
          cnt_d = LENW'(cnt_q + LENW'(1));
          if (LENW'(cnt_q + LENW'(1)) == len_q) begin
            state_d = DRAIN;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        // All pairs have been accepted. Wait until the last product is added.
        if (p_valid_s && (LENW'(acc_cnt_q + LENW'(1)) == len_q)) begin
          state_d = HOLD;
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (!out_valid_q) begin
          out_d       = acc_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset clears all state and takes priority over handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`ifdef MAC_PIPE_SATURATE_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe (INW=16, OUTW=32, MULT_STAGES=2, LENW=8).
module tb_mac_pipe;

  localparam int MS = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] input0, input1, init_value;
  logic [7:0]         vec_len;
  logic signed [31:0] dut_out;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int     len;
    int     init;
    int     n;
    int     a [4];
    int     b [4];
    bit     gaps;
    longint exp_out;
    bit     exp_ovf;
  } vec_t;

  vec_t tv [8];
  int   nv = 0;

  mac_pipe #(.INW(16), .OUTW(32), .MULT_STAGES(MS), .LENW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input0     (input0),
    .input1     (input1),
    .init_value (init_value),
    .vec_len    (vec_len),
    .out        (dut_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int len, input int init, input int n,
                         input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int a3, input int b3,
                         input bit gaps, input longint exp_out, input bit exp_ovf);
    tv[nv].len = len;  tv[nv].init = init; tv[nv].n = n;
    tv[nv].a = '{a0, a1, a2, a3};
    tv[nv].b = '{b0, b1, b2, b3};
    tv[nv].gaps = gaps; tv[nv].exp_out = exp_out; tv[nv].exp_ovf = exp_ovf;
    nv++;
  endtask

  // Apply one vector, wait for its result, check it, then accept it.
  task automatic run_vec(input int idx);
    int w;
    bit ready_bad;
    for (int i = 0; i < tv[idx].n; i++) begin
      in_valid = 1'b1;
      input0   = 16'(tv[idx].a[i]);
      input1   = 16'(tv[idx].b[i]);
      // Drive different values on later pairs. Only the first pair's values may be used.
      vec_len    = (i == 0) ? 8'(tv[idx].len) : 8'd9;
      init_value = (i == 0) ? 16'(tv[idx].init) : 16'sd1234;
      step();
      if (tv[idx].gaps && (i < tv[idx].n - 1)) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid  = 1'b0;
    w         = 0;
    ready_bad = 1'b0;
    while (!out_valid && w < 20) begin
      if (in_ready) ready_bad = 1'b1;
      step();
      w++;
    end
    check($sformatf("v%0d out_valid", idx), longint'(out_valid), 64'sd1);
    check($sformatf("v%0d in_ready_drain", idx), longint'(ready_bad), 64'sd0);
    check($sformatf("v%0d out", idx), longint'(dut_out), tv[idx].exp_out);
    check($sformatf("v%0d ovf", idx), longint'(ovf), longint'(tv[idx].exp_ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("v%0d idle_ready", idx), longint'(in_ready), 64'sd1);
  endtask

  initial begin
    bit bad;
    logic signed [31:0] held;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    input0 = '0; input1 = '0; init_value = '0; vec_len = '0;
    step(); step();
    reset = 1'b0;
    check("rst out", longint'(dut_out), 64'sd0);
    check("rst out_valid", longint'(out_valid), 64'sd0);
    check("rst ovf", longint'(ovf), 64'sd0);
    check("rst in_ready", longint'(in_ready), 64'sd1);

    // Latency: vec_len=1, init=5, (3,-4) gives -7 exactly MS+1 edges after acceptance.
    in_valid = 1'b1; input0 = 16'sd3; input1 = -16'sd4; init_value = 16'sd5; vec_len = 8'd1;
    step();                        // edge t: pair accepted
    in_valid = 1'b0;
    for (int k = 0; k < MS; k++) step();
    check("lat early", longint'(out_valid), 64'sd0);
    step();                        // edge t+MS+1
    check("lat valid", longint'(out_valid), 64'sd1);
    check("lat out", longint'(dut_out), -64'sd7);

    // Hold: keep out_ready=0 for 5 cycles while a new pair is offered.
    held = dut_out;
    bad  = 1'b0;
    in_valid = 1'b1; input0 = 16'sd100; input1 = 16'sd100; vec_len = 8'd1; init_value = 16'sd0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!out_valid || dut_out !== held || in_ready) bad = 1'b1;
    end
    check("hold stable", longint'(bad), 64'sd0);
    out_ready = 1'b1;               // in_valid is still high at the transfer edge
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    check("hold xfer valid", longint'(out_valid), 64'sd0);
    check("hold xfer ready", longint'(in_ready), 64'sd1);
    // If the offered pair had been accepted, a result would appear.
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    check("no accept in hold", longint'(bad), 64'sd0);

    // Reset mid-vector: 2 of 4 pairs, then reset while a new pair is offered.
    in_valid = 1'b1; input0 = 16'sd9; input1 = 16'sd9; vec_len = 8'd4; init_value = 16'sd0;
    step(); step();
    vec_len = 8'd1; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("midrst out", longint'(dut_out), 64'sd0);
    check("midrst ready", longint'(in_ready), 64'sd1);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    check("midrst no out", longint'(bad), 64'sd0);

    add_vec(2, 0, 2, 2, 3, 4, 5, 0, 0, 0, 0, 1'b0, 64'sd26, 1'b0);
    add_vec(4, 0, 4, 1, 1, 2, 2, 3, 3, 4, 4, 1'b1, 64'sd30, 1'b0);
`ifdef MAC_PIPE_SATURATE_EN
    add_vec(3, 0, 3, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0, 1'b0, 64'sd2147483647, 1'b1);
`else
    add_vec(3, 0, 3, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0, 1'b0, -64'sd1073741824, 1'b0);
`endif
    add_vec(0, -1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 1'b0, 64'sd48, 1'b0);
    add_vec(2, -100, 2, -5, 6, 7, -8, 0, 0, 0, 0, 1'b1, -64'sd186, 1'b0);
    add_vec(3, 1000, 3, 100, -200, -300, -400, 32767, 2, 0, 0, 1'b0, 64'sd166534, 1'b0);
    add_vec(1, -32768, 1, -32768, 32767, 0, 0, 0, 0, 0, 0, 1'b0, -64'sd1073741824, 1'b0);

    for (int v = 0; v < nv; v++) begin
      run_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter INW, default 16, signed operand and init_value width.
REQ-002 Parameter OUTW, default 64, signed accumulator/result width; SHALL satisfy OUTW >= 2*INW.
REQ-003 Parameter MULT_STAGES, default 2, multiplier pipeline registers, legal range 1..4.
REQ-004 Parameter LENW, default 8, width of vector-length input.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts operand pair this cycle.
REQ-009 input0, input1  input  INW each  signed operands.
REQ-010 init_value  input  INW  signed accumulator seed, sampled with the first pair of a vector.
REQ-011 vec_len  input  LENW  products per result, sampled with the first pair of a vector.
REQ-012 out  output  OUTW  signed result, held stable while out_valid=1.
REQ-013 out_valid  output  1  result available; out_ready  input  1  consumer accepts result.
REQ-014 ovf  output  1  sticky overflow flag for the current result.

Function
REQ-015 Transfer on input occurs when in_valid & in_ready; transfer on output when out_valid & out_ready.
REQ-016 FSM states IDLE, ACCUM, DRAIN, HOLD; IDLE->ACCUM on first input transfer; ACCUM->DRAIN on transfer of the vec_len-th pair; DRAIN->HOLD when the last product enters the accumulator; HOLD->IDLE on output transfer.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN and HOLD.
REQ-018 On the first transfer the accumulator SHALL load sign-extended init_value, then accumulate each product as it leaves the multiplier pipeline.
REQ-019 Products SHALL be full 2*INW-bit signed, sign-extended to OUTW before addition.
REQ-020 vec_len=0 SHALL be treated as 1.
REQ-021 In-vector element counter SHALL count accepted pairs only; gaps (in_valid=0) SHALL not disturb pipeline contents or count.
REQ-022 Latency: last pair accepted at edge t, out_valid SHALL be 1 after edge t+MULT_STAGES+1.
REQ-023 out, ovf and out_valid SHALL hold while out_valid=1 and out_ready=0.
REQ-024 First pair of the next vector SHALL NOT be accepted in the same cycle as the output transfer (in_ready=0 in HOLD).
REQ-025 ovf SHALL clear on the first transfer of each vector.

Reset
REQ-026 reset=1 SHALL, on the next edge, force state IDLE, counter 0, accumulator 0, all pipeline valid bits 0, out=0, out_valid=0, ovf=0; in_ready=1 afterwards.
REQ-027 reset asserted mid-vector SHALL discard all partial results with no output transfer.
REQ-028 reset SHALL take priority over every simultaneous handshake event.

Configuration
REQ-029 Macro MAC_PIPE_SATURATE_EN defined: each accumulation SHALL clamp to [-2^(OUTW-1), 2^(OUTW-1)-1] and set ovf when clamping occurs.
REQ-030 Macro undefined: accumulation SHALL wrap modulo 2^OUTW and ovf SHALL be tied 0.

Structure
REQ-031 Package mac_pkg SHALL hold the FSM state enum type and the saturation min/max constant functions of OUTW.
REQ-032 Sub-module mult_pipe (parameters INW, MULT_STAGES) SHALL implement the registered signed multiplier with valid bit shifting alongside data.

Verification
REQ-033 vec_len=1, init=5, pair (3,-4) -> out=-7, out_valid after MULT_STAGES+1 edges.
REQ-034 vec_len=4, init=0, pairs (1,1),(2,2),(3,3),(4,4) with one-cycle in_valid gaps -> out=30, in_ready=0 from DRAIN until output transfer.
REQ-035 Result ready, out_ready=0 for 5 cycles -> out and out_valid stable, in_ready=0; out_ready=1 -> transfer, IDLE next cycle.
REQ-036 INW=16, OUTW=32, vec_len=3, pairs (-32768,-32768)x3 -> with MAC_PIPE_SATURATE_EN out=2147483647, ovf=1; without, out=-1073741824, ovf=0.
REQ-037 reset pulsed after 2 of 4 pairs -> no out_valid; fresh vector vec_len=2, init=0, (2,3),(4,5) -> out=26.
REQ-038 vec_len=0, init=-1, pair (7,7) -> out=48, single-product vector.
